// File: rtl/loss_sequencer.sv
// loss_sequencer
//   Feeds the two-column loss stage. Paired H/Y rows from the upstream
//   buffers are issued to column 1 directly and to column 2 one cycle later.
//   The shared 2/N scale operand comes from a small ROM. The two per-column
//   gradient streams are realigned into row pairs, and completion is
//   signalled once all N pairs have returned.
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   start_in, cfg_batch_size_in   batch start and batch size N (IDLE only)
//   busy_out, done_out            batch in progress / completion pulse
//   cfg_err_out                   pulse when start is seen with an illegal N
//   h_valid_in, y_valid_in        upstream row valids
//   h_ready_out, y_ready_out      upstream row accept (always equal)
//   h_1_in, h_2_in, y_1_in, y_2_in        row data, Q8.8
//   H_1_out, Y_1_out, valid_1_out         column 1 operands
//   H_2_out, Y_2_out, valid_2_out         column 2 operands (one cycle later)
//   inv_batch_size_times_two_out          2/N in Q8.8
//   gradient_1_in, gradient_2_in, grad_valid_1_in, grad_valid_2_in
//                                         per-column gradients from the loss stage
//   grad_1_out, grad_2_out, grad_valid_out
//                                         realigned gradient pair
module loss_sequencer #(
    parameter int MAX_BATCH = 16,
    parameter int DATA_W    = 16,
    localparam int BW       = $clog2(MAX_BATCH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_in,
    input  logic [BW-1:0]            cfg_batch_size_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     cfg_err_out,
    input  logic                     h_valid_in,
    input  logic                     y_valid_in,
    output logic                     h_ready_out,
    output logic                     y_ready_out,
    input  logic signed [DATA_W-1:0] h_1_in,
    input  logic signed [DATA_W-1:0] h_2_in,
    input  logic signed [DATA_W-1:0] y_1_in,
    input  logic signed [DATA_W-1:0] y_2_in,
    output logic signed [DATA_W-1:0] H_1_out,
    output logic signed [DATA_W-1:0] Y_1_out,
    output logic signed [DATA_W-1:0] H_2_out,
    output logic signed [DATA_W-1:0] Y_2_out,
    output logic                     valid_1_out,
    output logic                     valid_2_out,
    output logic signed [DATA_W-1:0] inv_batch_size_times_two_out,
    input  logic signed [DATA_W-1:0] gradient_1_in,
    input  logic signed [DATA_W-1:0] gradient_2_in,
    input  logic                     grad_valid_1_in,
    input  logic                     grad_valid_2_in,
    output logic signed [DATA_W-1:0] grad_1_out,
    output logic signed [DATA_W-1:0] grad_2_out,
    output logic                     grad_valid_out
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    state_t                   state;
    logic [BW-1:0]            batch_n;
    logic [BW-1:0]            issued;
    logic [BW-1:0]            returned;
    logic                     cfg_ok;
    logic                     start_ok;
    logic                     accept;
    logic signed [DATA_W-1:0] h2_p0;
    logic signed [DATA_W-1:0] y2_p0;
    logic                     vld_p0;
    logic signed [DATA_W-1:0] hold;

    // round(512/n) in Q8.8 with ties rounded up: floor((1024 + n) / (2n)).
    // Entries outside 1..MAX_BATCH are never selected and read as zero.
    function automatic logic signed [DATA_W-1:0] round_inv(input int n);
        if (n < 1 || n > MAX_BATCH) begin
            return '0;
        end
        return DATA_W'((1024 + n) / (2 * n));
    endfunction

    logic signed [DATA_W-1:0] inv_rom [2**BW];

    for (genvar i = 0; i < 2**BW; i++) begin : g_rom
        assign inv_rom[i] = round_inv(i);
    end

    assign cfg_ok   = (cfg_batch_size_in != '0) && (cfg_batch_size_in <= BW'(MAX_BATCH));
    assign start_ok = (state == IDLE) && start_in && cfg_ok;

    // Both streams are accepted together or not at all.
    assign accept      = (state == RUN) && (issued < batch_n) && h_valid_in && y_valid_in;
    assign h_ready_out = accept;
    assign y_ready_out = accept;

    // Control FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state                        <= IDLE;
            batch_n                      <= '0;
            issued                       <= '0;
            busy_out                     <= 1'b0;
            done_out                     <= 1'b0;
            cfg_err_out                  <= 1'b0;
            inv_batch_size_times_two_out <= '0;
        end else begin
            done_out    <= 1'b0;
            cfg_err_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        if (cfg_ok) begin
                            batch_n  <= cfg_batch_size_in;
                            issued   <= '0;
                            busy_out <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            cfg_err_out <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    inv_batch_size_times_two_out <= inv_rom[batch_n];
                    state                        <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        issued <= issued + BW'(1);
                        if (issued + BW'(1) == batch_n) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (returned == batch_n) begin
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage p0: column 1 outputs and column 2 skew registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            H_1_out     <= '0;
            Y_1_out     <= '0;
            valid_1_out <= 1'b0;
            h2_p0       <= '0;
            y2_p0       <= '0;
            vld_p0      <= 1'b0;
            H_2_out     <= '0;
            Y_2_out     <= '0;
            valid_2_out <= 1'b0;
        end else begin
            valid_1_out <= accept;
            vld_p0      <= accept;
            if (accept) begin
                H_1_out <= h_1_in;
                Y_1_out <= y_1_in;
                h2_p0   <= h_2_in;
                y2_p0   <= y_2_in;
            end
            // Stage p1: column 2 outputs, one cycle behind column 1
            valid_2_out <= vld_p0;
            if (vld_p0) begin
                H_2_out <= h2_p0;
                Y_2_out <= y2_p0;
            end
        end
    end

    // Gradient realign: column 1 runs one cycle ahead, so its value waits in
    // hold until the matching column 2 value arrives. When both valids land
    // together, the pair takes the old hold value and hold takes the new one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold           <= '0;
            grad_1_out     <= '0;
            grad_2_out     <= '0;
            grad_valid_out <= 1'b0;
            returned       <= '0;
        end else begin
            grad_valid_out <= grad_valid_2_in;
            if (grad_valid_1_in) begin
                hold <= gradient_1_in;
            end
            if (grad_valid_2_in) begin
                grad_1_out <= hold;
                grad_2_out <= gradient_2_in;
            end
            if (start_ok) begin
                returned <= '0;
            end else if (grad_valid_2_in) begin
                returned <= returned + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_loss_sequencer.sv
// tb_loss_sequencer
//   Directed bench for loss_sequencer: batch issue with column skew, 2/N
//   values, gapped upstream valids, illegal sizes, gradient realignment,
//   mid-batch reset and start_in ignored while running.
module tb_loss_sequencer;

    localparam int MAX_BATCH = 16;
    localparam int BW        = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_in;
    logic [BW-1:0]      cfg_batch_size_in;
    logic               busy_out;
    logic               done_out;
    logic               cfg_err_out;
    logic               h_valid_in;
    logic               y_valid_in;
    logic               h_ready_out;
    logic               y_ready_out;
    logic signed [15:0] h_1_in;
    logic signed [15:0] h_2_in;
    logic signed [15:0] y_1_in;
    logic signed [15:0] y_2_in;
    logic signed [15:0] H_1_out;
    logic signed [15:0] Y_1_out;
    logic signed [15:0] H_2_out;
    logic signed [15:0] Y_2_out;
    logic               valid_1_out;
    logic               valid_2_out;
    logic signed [15:0] inv_batch_size_times_two_out;
    logic signed [15:0] gradient_1_in;
    logic signed [15:0] gradient_2_in;
    logic               grad_valid_1_in;
    logic               grad_valid_2_in;
    logic signed [15:0] grad_1_out;
    logic signed [15:0] grad_2_out;
    logic               grad_valid_out;

    loss_sequencer #(.MAX_BATCH(MAX_BATCH), .DATA_W(16)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .start_in                     (start_in),
        .cfg_batch_size_in            (cfg_batch_size_in),
        .busy_out                     (busy_out),
        .done_out                     (done_out),
        .cfg_err_out                  (cfg_err_out),
        .h_valid_in                   (h_valid_in),
        .y_valid_in                   (y_valid_in),
        .h_ready_out                  (h_ready_out),
        .y_ready_out                  (y_ready_out),
        .h_1_in                       (h_1_in),
        .h_2_in                       (h_2_in),
        .y_1_in                       (y_1_in),
        .y_2_in                       (y_2_in),
        .H_1_out                      (H_1_out),
        .Y_1_out                      (Y_1_out),
        .H_2_out                      (H_2_out),
        .Y_2_out                      (Y_2_out),
        .valid_1_out                  (valid_1_out),
        .valid_2_out                  (valid_2_out),
        .inv_batch_size_times_two_out (inv_batch_size_times_two_out),
        .gradient_1_in                (gradient_1_in),
        .gradient_2_in                (gradient_2_in),
        .grad_valid_1_in              (grad_valid_1_in),
        .grad_valid_2_in              (grad_valid_2_in),
        .grad_1_out                   (grad_1_out),
        .grad_2_out                   (grad_2_out),
        .grad_valid_out               (grad_valid_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected column outputs; data registers hold between valids.
    logic        v1e, v2e, pv;
    logic [15:0] h1e, y1e, h2e, y2e, ph2, py2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_model();
        v1e = 1'b0; v2e = 1'b0; pv = 1'b0;
        h1e = '0; y1e = '0; h2e = '0; y2e = '0; ph2 = '0; py2 = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  32'(busy_out),    0);
        chk({tag, "_done"},  32'(done_out),    0);
        chk({tag, "_err"},   32'(cfg_err_out), 0);
        chk({tag, "_hrdy"},  32'(h_ready_out), 0);
        chk({tag, "_yrdy"},  32'(y_ready_out), 0);
        chk({tag, "_H1"},    32'(H_1_out),     0);
        chk({tag, "_Y1"},    32'(Y_1_out),     0);
        chk({tag, "_H2"},    32'(H_2_out),     0);
        chk({tag, "_Y2"},    32'(Y_2_out),     0);
        chk({tag, "_v1"},    32'(valid_1_out), 0);
        chk({tag, "_v2"},    32'(valid_2_out), 0);
        chk({tag, "_inv"},   32'(inv_batch_size_times_two_out), 0);
        chk({tag, "_g1"},    32'(grad_1_out),  0);
        chk({tag, "_g2"},    32'(grad_2_out),  0);
        chk({tag, "_gv"},    32'(grad_valid_out), 0);
    endtask

    // Start a batch and issue n rows; y_valid_in toggles when gappy is set.
    // With poke set, start_in is pulsed (N=5) in the first RUN cycle.
    task automatic run_batch(input int n, input bit gappy, input logic [15:0] inv_exp, input bit poke);
        int sent = 0;
        int tail = 0;
        int c = 0;
        logic acc;
        start_in = 1'b1;
        cfg_batch_size_in = n[BW-1:0];
        tick();
        start_in = 1'b0;
        #1;
        chk("load_busy", 32'(busy_out), 1);
        chk("load_rdy", 32'(h_ready_out), 0);
        tick();
        while ((sent < n || tail < 3) && c < 200) begin
            chk("inv", 32'(inv_batch_size_times_two_out), 32'(inv_exp));
            chk("busy", 32'(busy_out), 1);
            chk("done_early", 32'(done_out), 0);
            chk("valid_1", 32'(valid_1_out), 32'(v1e));
            chk("H_1", 32'(H_1_out), 32'(h1e));
            chk("Y_1", 32'(Y_1_out), 32'(y1e));
            chk("valid_2", 32'(valid_2_out), 32'(v2e));
            chk("H_2", 32'(H_2_out), 32'(h2e));
            chk("Y_2", 32'(Y_2_out), 32'(y2e));
            h_valid_in = (sent < n);
            y_valid_in = gappy ? (c % 2 == 0) : 1'b1;
            h_1_in = 16'(16'h0100 + sent);
            y_1_in = 16'(16'h0200 + sent);
            h_2_in = 16'(16'h0180 + sent);
            y_2_in = 16'(16'h0280 + sent);
            start_in = poke && (c == 0);
            if (poke && c == 0) cfg_batch_size_in = 5'd5;
            #1;
            acc = (sent < n) && y_valid_in;
            chk("h_ready", 32'(h_ready_out), 32'(acc));
            chk("y_ready", 32'(y_ready_out), 32'(acc));
            v2e = pv;
            if (pv) begin
                h2e = ph2;
                y2e = py2;
            end
            pv  = acc;
            v1e = acc;
            if (acc) begin
                h1e = h_1_in;
                y1e = y_1_in;
                ph2 = h_2_in;
                py2 = y_2_in;
                sent++;
            end
            if (sent == n) tail++;
            c++;
            tick();
        end
        if (c >= 200) chk("issue_timeout", 32'(sent), 32'(n));
        start_in = 1'b0;
        h_valid_in = 1'b0;
        y_valid_in = 1'b0;
        v1e = 1'b0; v2e = 1'b0; pv = 1'b0;
    endtask

    // Return n gradient pairs, column 1 one cycle ahead of column 2.
    task automatic return_grads(input int n, input logic [15:0] inv_exp);
        for (int k = 0; k < n; k++) begin
            grad_valid_1_in = 1'b1;
            gradient_1_in = 16'(16'h1000 + k);
            tick();
            grad_valid_1_in = 1'b0;
            grad_valid_2_in = 1'b1;
            gradient_2_in = 16'(16'h2000 + k);
            #1;
            chk("gv_low", 32'(grad_valid_out), 0);
            tick();
            grad_valid_2_in = 1'b0;
            #1;
            chk("gv", 32'(grad_valid_out), 1);
            chk("g1", 32'(grad_1_out), 32'(16'h1000 + k));
            chk("g2", 32'(grad_2_out), 32'(16'h2000 + k));
            chk("done_pre", 32'(done_out), 0);
        end
        tick();
        #1;
        chk("done", 32'(done_out), 1);
        chk("done_busy", 32'(busy_out), 0);
        chk("inv_hold", 32'(inv_batch_size_times_two_out), 32'(inv_exp));
        tick();
        #1;
        chk("done_end", 32'(done_out), 0);
        chk("idle_busy", 32'(busy_out), 0);
    endtask

    task automatic err_case(input int n);
        h_valid_in = 1'b1;
        y_valid_in = 1'b1;
        start_in = 1'b1;
        cfg_batch_size_in = n[BW-1:0];
        tick();
        start_in = 1'b0;
        #1;
        chk("err_pulse", 32'(cfg_err_out), 1);
        chk("err_busy", 32'(busy_out), 0);
        chk("err_hrdy", 32'(h_ready_out), 0);
        chk("err_yrdy", 32'(y_ready_out), 0);
        tick();
        #1;
        chk("err_once", 32'(cfg_err_out), 0);
        chk("err_busy2", 32'(busy_out), 0);
        chk("err_rdy2", 32'(h_ready_out), 0);
        h_valid_in = 1'b0;
        y_valid_in = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start_in = 1'b0;
        cfg_batch_size_in = '0;
        h_valid_in = 1'b0;
        y_valid_in = 1'b0;
        h_1_in = '0; h_2_in = '0; y_1_in = '0; y_2_in = '0;
        gradient_1_in = '0; gradient_2_in = '0;
        grad_valid_1_in = 1'b0; grad_valid_2_in = 1'b0;
        clear_model();
        repeat (2) tick();
        #1;
        check_zero("reset");
        rst = 1'b1;
        tick();

        run_batch(4, 1'b0, 16'd128, 1'b0);
        return_grads(4, 16'd128);
        run_batch(3, 1'b0, 16'd171, 1'b0);
        return_grads(3, 16'd171);
        run_batch(1, 1'b0, 16'd512, 1'b0);
        return_grads(1, 16'd512);
        run_batch(16, 1'b0, 16'd32, 1'b0);
        return_grads(16, 16'd32);
        run_batch(4, 1'b1, 16'd128, 1'b0);
        return_grads(4, 16'd128);

        err_case(0);
        err_case(17);

        // Reset after two of four rows, with a gradient sitting in hold.
        start_in = 1'b1;
        cfg_batch_size_in = 5'd4;
        tick();
        start_in = 1'b0;
        tick();
        h_valid_in = 1'b1;
        y_valid_in = 1'b1;
        h_1_in = 16'h0100; y_1_in = 16'h0200; h_2_in = 16'h0180; y_2_in = 16'h0280;
        tick();
        h_1_in = 16'h0101; y_1_in = 16'h0201; h_2_in = 16'h0181; y_2_in = 16'h0281;
        grad_valid_1_in = 1'b1;
        gradient_1_in = 16'h7777;
        tick();
        grad_valid_1_in = 1'b0;
        rst = 1'b0;
        h_valid_in = 1'b0;
        y_valid_in = 1'b0;
        tick();
        #1;
        check_zero("mid_rst");
        rst = 1'b1;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("rst_no_done", 32'(done_out), 0);
            chk("rst_no_busy", 32'(busy_out), 0);
        end
        grad_valid_2_in = 1'b1;
        gradient_2_in = 16'h0011;
        tick();
        grad_valid_2_in = 1'b0;
        #1;
        chk("hold_clr_gv", 32'(grad_valid_out), 1);
        chk("hold_clr_g1", 32'(grad_1_out), 0);
        chk("hold_clr_g2", 32'(grad_2_out), 32'h0011);
        tick();

        // Fresh N=2 batch, start_in poked while running, back-to-back gradients.
        run_batch(2, 1'b0, 16'd256, 1'b1);
        grad_valid_1_in = 1'b1;
        gradient_1_in = 16'h0080;
        tick();
        gradient_1_in = 16'h0100;
        grad_valid_2_in = 1'b1;
        gradient_2_in = 16'h0020;
        #1;
        chk("b2b_gv_low", 32'(grad_valid_out), 0);
        tick();
        grad_valid_1_in = 1'b0;
        gradient_2_in = 16'h0040;
        #1;
        chk("b2b_gv0", 32'(grad_valid_out), 1);
        chk("b2b_g1_0", 32'(grad_1_out), 32'h0080);
        chk("b2b_g2_0", 32'(grad_2_out), 32'h0020);
        tick();
        grad_valid_2_in = 1'b0;
        #1;
        chk("b2b_gv1", 32'(grad_valid_out), 1);
        chk("b2b_g1_1", 32'(grad_1_out), 32'h0100);
        chk("b2b_g2_1", 32'(grad_2_out), 32'h0040);
        chk("b2b_done_pre", 32'(done_out), 0);
        tick();
        #1;
        chk("b2b_done", 32'(done_out), 1);
        chk("b2b_inv", 32'(inv_batch_size_times_two_out), 32'd256);
        tick();
        #1;
        chk("b2b_done_end", 32'(done_out), 0);
        chk("b2b_busy", 32'(busy_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
